// File: rtl/ram_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : ram_load_ctrl
// Brief   : Steers a valid/ready byte stream into the feature-data RAM or one
//           of NUM_KERNELS weight RAM banks, with full/release frame handshake.
//           Define RAM_LOAD_PINGPONG_EN for two ping-pong data banks.
// Revision: 1.0 - initial release
// ============================================================================
module ram_load_ctrl #(
  parameter int DATA_W       = 8,
  parameter int DATA_DEPTH   = 64,
  parameter int WEIGHT_DEPTH = 27,
  parameter int NUM_KERNELS  = 2,
  parameter int MODE_DATA    = 0,
  parameter int MODE_WEIGHT  = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            clear,
  input  logic                            mode,
  input  logic                            in_valid,
  input  logic [DATA_W-1:0]               in_data,
  output logic                            in_ready,
  input  logic                            data_release,
  output logic                            data_ram_we,
  output logic [$clog2(DATA_DEPTH)-1:0]   data_ram_waddr,
  output logic [DATA_W-1:0]               data_ram_wdata,
  output logic                            data_wr_bank,
  output logic                            data_rd_bank,
  output logic                            data_avail,
  output logic                            data_done,
  output logic [NUM_KERNELS-1:0]          weight_ram_we,
  output logic [$clog2(WEIGHT_DEPTH)-1:0] weight_ram_waddr,
  output logic [DATA_W-1:0]               weight_ram_wdata,
  output logic                            weight_done
);

  localparam int DAW = $clog2(DATA_DEPTH);
  localparam int WAW = $clog2(WEIGHT_DEPTH);
  localparam int KW  = (NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1;
  localparam logic [DAW-1:0] c_DATA_LAST = DAW'(DATA_DEPTH - 1);
  localparam logic [WAW-1:0] c_WT_LAST   = WAW'(WEIGHT_DEPTH - 1);
  localparam logic [KW-1:0]  c_K_LAST    = KW'(NUM_KERNELS - 1);

  logic                   w_is_data;
  logic                   w_is_weight;
  logic                   w_wr_full;
  logic                   w_rd_full;
  logic                   w_wr_bank;
  logic                   w_rd_bank;
  logic                   w_data_beat;
  logic                   w_wt_beat;
  logic                   w_frame_end;
  logic                   w_kernel_end;
  logic                   w_rel_take;

  logic [DAW-1:0]         r_data_ptr;
  logic [WAW-1:0]         r_wt_ptr;
  logic [KW-1:0]          r_kidx;
  logic                   r_data_we;
  logic [DAW-1:0]         r_data_waddr;
  logic [DATA_W-1:0]      r_data_wdata;
  logic                   r_data_bank;
  logic                   r_data_done;
  logic [NUM_KERNELS-1:0] r_wt_we;
  logic [WAW-1:0]         r_wt_waddr;
  logic [DATA_W-1:0]      r_wt_wdata;
  logic                   r_wt_done;

  assign w_is_data    = (mode == 1'(MODE_DATA));
  assign w_is_weight  = (mode == 1'(MODE_WEIGHT));
  assign in_ready     = !clear && (w_is_weight || (w_is_data && !w_wr_full));
  assign w_data_beat  = in_valid && in_ready && w_is_data;
  assign w_wt_beat    = in_valid && in_ready && w_is_weight;
  assign w_frame_end  = w_data_beat && (r_data_ptr == c_DATA_LAST);
  assign w_kernel_end = w_wt_beat && (r_wt_ptr == c_WT_LAST);
  assign w_rel_take   = data_release && w_rd_full;

`ifdef RAM_LOAD_PINGPONG_EN
  logic [1:0] r_full;
  logic       r_wr_bank;
  logic       r_rd_bank;

  assign w_wr_bank  = r_wr_bank;
  assign w_rd_bank  = r_rd_bank;
  assign w_wr_full  = r_full[r_wr_bank];
  assign w_rd_full  = r_full[r_rd_bank];
  assign data_avail = |r_full;

  // Set is placed after clear so a same-bank collision leaves the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full    <= 2'b00;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
    end else if (clear) begin
      r_full    <= 2'b00;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
    end else begin
      if (w_rel_take) begin
        r_full[r_rd_bank] <= 1'b0;
        r_rd_bank         <= ~r_rd_bank;
      end
      if (w_frame_end) begin
        r_full[r_wr_bank] <= 1'b1;
        r_wr_bank         <= ~r_wr_bank;
      end
    end
  end
`else
  logic r_full;

  assign w_wr_bank  = 1'b0;
  assign w_rd_bank  = 1'b0;
  assign w_wr_full  = r_full;
  assign w_rd_full  = r_full;
  assign data_avail = r_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= 1'b0;
    end else if (clear) begin
      r_full <= 1'b0;
    end else if (w_frame_end) begin
      r_full <= 1'b1;
    end else if (w_rel_take) begin
      r_full <= 1'b0;
    end
  end
`endif

  // Write port registers; the bank output travels with its beat so it lines up with the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_ptr   <= '0;
      r_wt_ptr     <= '0;
      r_kidx       <= '0;
      r_data_we    <= 1'b0;
      r_data_waddr <= '0;
      r_data_wdata <= '0;
      r_data_bank  <= 1'b0;
      r_data_done  <= 1'b0;
      r_wt_we      <= '0;
      r_wt_waddr   <= '0;
      r_wt_wdata   <= '0;
      r_wt_done    <= 1'b0;
    end else if (clear) begin
      r_data_ptr   <= '0;
      r_wt_ptr     <= '0;
      r_kidx       <= '0;
      r_data_we    <= 1'b0;
      r_data_waddr <= '0;
      r_data_wdata <= '0;
      r_data_bank  <= 1'b0;
      r_data_done  <= 1'b0;
      r_wt_we      <= '0;
      r_wt_waddr   <= '0;
      r_wt_wdata   <= '0;
      r_wt_done    <= 1'b0;
    end else begin
      r_data_we   <= w_data_beat;
      r_data_done <= w_frame_end;
      r_wt_we     <= w_wt_beat ? (NUM_KERNELS'(1) << r_kidx) : '0;
      r_wt_done   <= w_kernel_end && (r_kidx == c_K_LAST);
      if (w_data_beat) begin
        r_data_waddr <= r_data_ptr;
        r_data_wdata <= in_data;
        r_data_bank  <= w_wr_bank;
        r_data_ptr   <= w_frame_end ? '0 : r_data_ptr + DAW'(1);
      end
      if (w_wt_beat) begin
        r_wt_waddr <= r_wt_ptr;
        r_wt_wdata <= in_data;
        r_wt_ptr   <= w_kernel_end ? '0 : r_wt_ptr + WAW'(1);
        if (w_kernel_end) begin
          r_kidx <= (r_kidx == c_K_LAST) ? '0 : r_kidx + KW'(1);
        end
      end
    end
  end

  assign data_ram_we      = r_data_we;
  assign data_ram_waddr   = r_data_waddr;
  assign data_ram_wdata   = r_data_wdata;
  assign data_wr_bank     = r_data_bank;
  assign data_rd_bank     = w_rd_bank;
  assign data_done        = r_data_done;
  assign weight_ram_we    = r_wt_we;
  assign weight_ram_waddr = r_wt_waddr;
  assign weight_ram_wdata = r_wt_wdata;
  assign weight_done      = r_wt_done;

endmodule
`default_nettype wire

// File: tb/tb_ram_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_ram_load_ctrl
// Brief   : Self-checking bench for ram_load_ctrl: directed table, corner
//           sequences and random traffic against a frame-count reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ram_load_ctrl;

  localparam int DW = 8;
  localparam int DD = 64;
  localparam int WD = 27;
  localparam int NK = 2;
`ifdef RAM_LOAD_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          mode;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          data_release;
  logic          data_ram_we;
  logic [5:0]    data_ram_waddr;
  logic [DW-1:0] data_ram_wdata;
  logic          data_wr_bank;
  logic          data_rd_bank;
  logic          data_avail;
  logic          data_done;
  logic [NK-1:0] weight_ram_we;
  logic [4:0]    weight_ram_waddr;
  logic [DW-1:0] weight_ram_wdata;
  logic          weight_done;

  ram_load_ctrl #(
    .DATA_W(DW), .DATA_DEPTH(DD), .WEIGHT_DEPTH(WD), .NUM_KERNELS(NK),
    .MODE_DATA(0), .MODE_WEIGHT(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .mode(mode),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .data_release(data_release),
    .data_ram_we(data_ram_we), .data_ram_waddr(data_ram_waddr),
    .data_ram_wdata(data_ram_wdata), .data_wr_bank(data_wr_bank),
    .data_rd_bank(data_rd_bank), .data_avail(data_avail), .data_done(data_done),
    .weight_ram_we(weight_ram_we), .weight_ram_waddr(weight_ram_waddr),
    .weight_ram_wdata(weight_ram_wdata), .weight_done(weight_done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: beats and frames counted since the last reset/clear.
  int            n_d, n_w, fc, rc;
  logic          e_dwe, e_ddone, e_wdone, e_dbank;
  int            e_daddr, e_waddr;
  logic [DW-1:0] e_dwdata, e_wwdata;
  logic [NK-1:0] e_wwe;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    n_d = 0; n_w = 0; fc = 0; rc = 0;
    e_dwe = 0; e_ddone = 0; e_wdone = 0; e_dbank = 0;
    e_daddr = 0; e_waddr = 0; e_dwdata = '0; e_wwdata = '0; e_wwe = '0;
  endtask

  task automatic check_outputs();
    chk("data_ram_we", data_ram_we, e_dwe);
    chk("data_ram_waddr", data_ram_waddr, e_daddr);
    chk("data_ram_wdata", data_ram_wdata, e_dwdata);
    chk("data_wr_bank", data_wr_bank, e_dbank);
    chk("data_done", data_done, e_ddone);
    chk("data_rd_bank", data_rd_bank, rc % NB);
    chk("data_avail", data_avail, (fc - rc) > 0);
    chk("weight_ram_we", weight_ram_we, e_wwe);
    chk("weight_ram_waddr", weight_ram_waddr, e_waddr);
    chk("weight_ram_wdata", weight_ram_wdata, e_wwdata);
    chk("weight_done", weight_done, e_wdone);
  endtask

  // One clock: entered and left at posedge+1.
  task automatic step(input logic m, input logic v, input logic [DW-1:0] d,
                      input logic rel, input logic clr);
    logic exp_r, acc, rel_ok;
    check_outputs();
    mode = m; in_valid = v; in_data = d; data_release = rel; clear = clr;
    #1;
    exp_r = !clr && (m || ((fc - rc) < NB));
    chk("in_ready", in_ready, exp_r);
    if (clr) begin
      model_reset();
    end else begin
      acc    = v && exp_r;
      rel_ok = rel && ((fc - rc) > 0);
      e_dwe = 0; e_ddone = 0; e_wwe = '0; e_wdone = 0;
      if (acc && !m) begin
        e_dwe    = 1;
        e_daddr  = n_d % DD;
        e_dwdata = d;
        e_dbank  = ((n_d / DD) % NB) != 0;
        e_ddone  = (n_d % DD) == DD - 1;
        n_d++;
        if (e_ddone) fc++;
      end
      if (acc && m) begin
        e_wwe    = NK'(1) << ((n_w / WD) % NK);
        e_waddr  = n_w % WD;
        e_wwdata = d;
        e_wdone  = (n_w % (WD * NK)) == WD * NK - 1;
        n_w++;
      end
      if (rel_ok) rc++;
    end
    @(posedge clk); #1;
    mode = 0; in_valid = 0; data_release = 0; clear = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    #2;
    model_reset();
    check_outputs();
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic beats(input logic m, input int n);
    for (int i = 0; i < n; i++) step(m, 1'b1, DW'($urandom), 1'b0, 1'b0);
  endtask

  typedef struct {
    logic          m, v;
    logic [DW-1:0] d;
    logic          rel, clr;
    logic          ex_ready, ex_dwe;
    int            ex_daddr;
    logic [NK-1:0] ex_wwe;
    int            ex_waddr;
  } vec_t;

  vec_t tbl [8];

  initial begin
    tbl[0] = '{m:0, v:1, d:8'hA1, rel:0, clr:0, ex_ready:1, ex_dwe:1, ex_daddr:0, ex_wwe:2'b00, ex_waddr:0};
    tbl[1] = '{m:1, v:1, d:8'h11, rel:0, clr:0, ex_ready:1, ex_dwe:0, ex_daddr:0, ex_wwe:2'b01, ex_waddr:0};
    tbl[2] = '{m:0, v:1, d:8'hA2, rel:0, clr:0, ex_ready:1, ex_dwe:1, ex_daddr:1, ex_wwe:2'b00, ex_waddr:0};
    tbl[3] = '{m:0, v:0, d:8'h00, rel:0, clr:0, ex_ready:1, ex_dwe:0, ex_daddr:1, ex_wwe:2'b00, ex_waddr:0};
    tbl[4] = '{m:1, v:1, d:8'h12, rel:0, clr:1, ex_ready:0, ex_dwe:0, ex_daddr:0, ex_wwe:2'b00, ex_waddr:0};
    tbl[5] = '{m:1, v:1, d:8'h13, rel:0, clr:0, ex_ready:1, ex_dwe:0, ex_daddr:0, ex_wwe:2'b01, ex_waddr:0};
    tbl[6] = '{m:0, v:1, d:8'hA3, rel:0, clr:0, ex_ready:1, ex_dwe:1, ex_daddr:0, ex_wwe:2'b00, ex_waddr:0};
    tbl[7] = '{m:0, v:1, d:8'hA4, rel:1, clr:0, ex_ready:1, ex_dwe:1, ex_daddr:1, ex_wwe:2'b00, ex_waddr:0};

    rst_n = 0; clear = 0; mode = 0; in_valid = 0; in_data = '0; data_release = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1;
    #1;
    chk("in_ready_after_reset", in_ready, 1);
    @(posedge clk); #1;

    // Directed vector table
    for (int i = 0; i < 8; i++) begin
      mode = tbl[i].m; clear = tbl[i].clr;
      #1;
      chk("tbl_in_ready", in_ready, tbl[i].ex_ready);
      @(posedge clk); #1;
      clear = 0;
      // realign to the step timing: step performs its own drive
      #0;
      do_reset();
      for (int j = 0; j <= i; j++) step(tbl[j].m, tbl[j].v, tbl[j].d, tbl[j].rel, tbl[j].clr);
      chk("tbl_data_we", data_ram_we, tbl[i].ex_dwe);
      chk("tbl_data_addr", data_ram_waddr, tbl[i].ex_daddr);
      chk("tbl_weight_we", weight_ram_we, tbl[i].ex_wwe);
      chk("tbl_weight_addr", weight_ram_waddr, tbl[i].ex_waddr);
      if (tbl[i].ex_dwe) chk("tbl_data_wdata", data_ram_wdata, tbl[i].d);
    end

    // Full data frame, then stall (single bank) until release
    do_reset();
    beats(1'b0, DD);
    chk("frame_done", data_done, 1);
    chk("frame_last_addr", data_ram_waddr, DD - 1);
    chk("frame_avail", data_avail, 1);
    mode = 0;
    #1;
    chk("ready_after_frame", in_ready, (NB == 1) ? 0 : 1);
    step(1'b0, 1'b1, 8'h55, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h56, 1'b1, 1'b0);
    step(1'b0, 1'b1, 8'h57, 1'b0, 1'b0);

    // Two kernels of weights
    do_reset();
    beats(1'b1, WD * NK);
    chk("weight_done_last", weight_done, 1);
    chk("weight_last_bank", weight_ram_we, 2'b10);
    chk("weight_last_addr", weight_ram_waddr, WD - 1);

    // Interleaved targets keep independent counters
    do_reset();
    beats(1'b0, 10);
    beats(1'b1, 5);
    beats(1'b0, 10);
    chk("interleave_data_addr", data_ram_waddr, 19);
    chk("interleave_wt_addr", weight_ram_waddr, 4);

    // Fill beyond all banks without release, then a single release
    do_reset();
    beats(1'b0, DD * 2 + 6);
    chk("overfill_avail", data_avail, 1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("release_rd_bank", data_rd_bank, (NB == 2) ? 1 : 0);
    beats(1'b0, 3);

    // Release on the same edge as a frame completion
    do_reset();
    beats(1'b0, DD - 1);
    step(1'b0, 1'b1, 8'hEE, 1'b1, 1'b0);
    chk("same_edge_avail", data_avail, 1);
    chk("same_edge_done", data_done, 1);
    beats(1'b0, DD);
    step(1'b0, 1'b1, 8'hEF, 1'b1, 1'b0);
    beats(1'b0, 4);

    // Reset and clear mid-frame
    do_reset();
    beats(1'b0, 30);
    do_reset();
    step(1'b0, 1'b1, 8'h77, 1'b0, 1'b0);
    chk("post_reset_addr", data_ram_waddr, 0);
    chk("post_reset_bank", data_wr_bank, 0);
    beats(1'b0, 30);
    beats(1'b1, 7);
    step(1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
    chk("clear_data_we", data_ram_we, 0);
    chk("clear_data_addr", data_ram_waddr, 0);
    step(1'b1, 1'b1, 8'h78, 1'b0, 1'b0);
    chk("post_clear_wt_addr", weight_ram_waddr, 0);
    chk("post_clear_wt_bank", weight_ram_we, 2'b01);

    // Random traffic
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 8), DW'($urandom),
           ($urandom_range(0, 99) < 3), ($urandom_range(0, 999) < 3));
    end
    check_outputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
